// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and constants for the push-button debouncer.
// Optional auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
package key_debounce_pkg;

  // Per-key debounce state
  typedef enum logic [1:0] {
    UP       = 2'd0,
    CHK_DOWN = 2'd1,
    DOWN     = 2'd2,
    CHK_UP   = 2'd3
  } key_state_t;

  // Raw key pins pull low when pressed
  localparam logic KEY_ACTIVE_LEVEL = 1'b0;

  // Synchroniser flops reset to the released pin level
  localparam logic KEY_SYNC_RESET = 1'b1;

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: debounce state machine for a single key.
// Accepts a level change after DEBOUNCE_TICKS consecutive equal samples and
// emits one-clock press/release events. With KEY_DEBOUNCE_REPEAT_EN defined,
// a hold counter adds auto-repeat press events while the key stays down.
module key_debounce_fsm
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned HOLD_TICKS     = 500,
  parameter int unsigned REPEAT_TICKS   = 100
`endif
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic tick,
  input  logic pressed,
  output logic key_level,
  output logic press_evt,
  output logic release_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             repeat_hit;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);

  logic [HOLD_W-1:0] hold;

  // A held-down sample that completes the hold interval fires a repeat
  always_comb repeat_hit = (state == DOWN) && pressed && (hold == HOLD_LAST);

  // Hold counter: cleared on press acceptance, frozen outside DOWN; reloading
  // to HOLD_TICKS-REPEAT_TICKS spaces later repeats REPEAT_TICKS apart
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hold <= '0;
    end else if (tick) begin
      if ((state == CHK_DOWN) && pressed && (cnt == CNT_LAST)) begin
        hold <= '0;
      end else if ((state == DOWN) && pressed) begin
        hold <= repeat_hit ? HOLD_RELOAD : hold + 1'b1;
      end
    end
  end
`else
  // Auto-repeat not built: one press event per accepted press
  always_comb repeat_hit = 1'b0;
`endif

  // Debounced level is high once a press is accepted until a release is
  always_comb key_level = (state == DOWN) || (state == CHK_UP);

  // Debounce FSM; advances only on sample ticks, event flops self-clear
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= UP;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      if (tick) begin
        case (state)
          UP: begin
            if (pressed) begin
              state <= CHK_DOWN;
              cnt   <= CNT_ONE;
            end
          end
          CHK_DOWN: begin
            if (!pressed) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= DOWN;
              cnt       <= '0;
              press_evt <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DOWN: begin
            if (!pressed) begin
              state <= CHK_UP;
              cnt   <= CNT_ONE;
            end else begin
              press_evt <= repeat_hit;
            end
          end
          CHK_UP: begin
            if (pressed) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state       <= UP;
              cnt         <= '0;
              release_evt <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= UP;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces N_KEYS active-low push-buttons
// and delivers a clean level plus one-clock press/release events per key.
// Define KEY_DEBOUNCE_REPEAT_EN to add auto-repeat press events while held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SAMPLE_DIV     = 50_000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned N_KEYS         = 4,
  parameter int unsigned HOLD_TICKS     = 500,
  parameter int unsigned REPEAT_TICKS   = 100
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [N_KEYS-1:0] iKEY,
  output logic [N_KEYS-1:0] oKEY_STATE,
  output logic [N_KEYS-1:0] oKEY_PRESS,
  output logic [N_KEYS-1:0] oKEY_RELEASE
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  if ((SAMPLE_DIV < 2) || (DEBOUNCE_TICKS < 2) || (N_KEYS < 1) ||
      (CLK_HZ < SAMPLE_DIV) || (REPEAT_TICKS < 1) ||
      (HOLD_TICKS < REPEAT_TICKS)) begin : g_bad_params
    $error("key_debounce: invalid parameter set");
  end

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] pressed;
  logic [DIV_W-1:0]  div;
  logic              tick;

  // Two-flop synchroniser on the asynchronous key pins
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1 <= {N_KEYS{KEY_SYNC_RESET}};
      sync2 <= {N_KEYS{KEY_SYNC_RESET}};
    end else begin
      sync1 <= iKEY;
      sync2 <= sync1;
    end
  end

  // Map the pin polarity to a pressed flag
  always_comb pressed = ~(sync2 ^ {N_KEYS{KEY_ACTIVE_LEVEL}});

  // Shared sample-tick divider, wraps at SAMPLE_DIV-1
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Tick is high for the final count of each divider period
  always_comb tick = (div == DIV_LAST);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
`ifdef KEY_DEBOUNCE_REPEAT_EN
      ,
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
`endif
    ) u_fsm (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .tick        (tick),
      .pressed     (pressed[k]),
      .key_level   (oKEY_STATE[k]),
      .press_evt   (oKEY_PRESS[k]),
      .release_evt (oKEY_RELEASE[k])
    );
  end

endmodule
